// File: rtl/pipe_issue_pkg.sv
// pipe_issue_pkg: forwarding selects, ID/EXE register layout and the forwarding-priority function.
package pipe_issue_pkg;
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_EALU = 2'd1;
    localparam logic [1:0] FWD_MALU = 2'd2;
    localparam logic [1:0] FWD_MMO = 2'd3;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic        jal;
        logic        aluimm;
        logic        shift;
        logic [3:0]  aluc;
        logic [4:0]  rn0;
        logic [31:0] pc4;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } estate_t;

    // EXE beats MEM; a load still in EXE has no value yet, so it never forwards
    function automatic logic [1:0] fwd_sel(input logic ewreg, em2reg, input logic [4:0] ern,
                                           input logic mwreg, mm2reg, input logic [4:0] mrn, src);
        return (ewreg && !em2reg && ern != 5'd0 && ern == src) ? FWD_EALU :
               (mwreg && mrn != 5'd0 && mrn == src) ? (mm2reg ? FWD_MMO : FWD_MALU) : FWD_RF;
    endfunction
endpackage

// File: rtl/pipe_issue_if.sv
// pipe_issue_if: ID inputs, EXE/MEM bypass inputs and the registered EXE-side outputs of pipe_issue.
interface pipe_issue_if;
    logic        dwreg, dm2reg, dwmem, djal, daluimm, dshift;
    logic [3:0]  daluc;
    logic [31:0] dpc4, dimm, dqa, dqb;
    logic [4:0]  drs, drt, drn0;
    logic        duse_rs, duse_rt;
    logic [4:0]  ern;
    logic [31:0] ealu;
    logic        mwreg, mm2reg;
    logic [4:0]  mrn;
    logic [31:0] malu, mmo;
    logic        ewreg, em2reg, ewmem, ejal, ealuimm, eshift;
    logic [3:0]  ealuc;
    logic [31:0] epc4, ea, eb, eimm;
    logic [4:0]  ern0;
    logic        wpcir;
    logic [1:0]  fwda, fwdb;

    modport master (
        output dwreg, dm2reg, dwmem, djal, daluimm, dshift, daluc, dpc4, dimm, dqa, dqb,
               drs, drt, drn0, duse_rs, duse_rt, ern, ealu, mwreg, mm2reg, mrn, malu, mmo,
        input  ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, epc4, ea, eb, eimm,
               ern0, wpcir, fwda, fwdb
    );
    modport slave (
        input  dwreg, dm2reg, dwmem, djal, daluimm, dshift, daluc, dpc4, dimm, dqa, dqb,
               drs, drt, drn0, duse_rs, duse_rt, ern, ealu, mwreg, mm2reg, mrn, malu, mmo,
        output ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, epc4, ea, eb, eimm,
               ern0, wpcir, fwda, fwdb
    );
endinterface

// File: rtl/pipe_issue_mux4x32.sv
// mux4x32: 32-bit four-way select, companion to mux2x32.
module mux4x32 (
    input  logic [31:0] a0_i,
    input  logic [31:0] a1_i,
    input  logic [31:0] a2_i,
    input  logic [31:0] a3_i,
    input  logic [1:0]  s_i,
    output logic [31:0] y_o
);
    assign y_o = s_i[1] ? (s_i[0] ? a3_i : a2_i) : (s_i[0] ? a1_i : a0_i);
endmodule

// File: rtl/pipe_issue.sv
// pipe_issue: ID/EXE register with EXE/MEM operand forwarding and load-use bubble insertion.
module pipe_issue
    import pipe_issue_pkg::*;
(
    input  logic      clock,
    input  logic      resetn,
    pipe_issue_if.slave io
);
    estate_t     e_q, e_d;
    logic [1:0]  fwda, fwdb;
    logic [31:0] a_fwd, b_fwd;
    logic        stall;

    assign fwda = fwd_sel(e_q.wreg, e_q.m2reg, io.ern, io.mwreg, io.mm2reg, io.mrn, io.drs);
    assign fwdb = fwd_sel(e_q.wreg, e_q.m2reg, io.ern, io.mwreg, io.mm2reg, io.mrn, io.drt);
    assign stall = e_q.wreg && e_q.m2reg && io.ern != 5'd0 &&
                   ((io.duse_rs && io.ern == io.drs) || (io.duse_rt && io.ern == io.drt));

    mux4x32 u_mux_a (.a0_i(io.dqa), .a1_i(io.ealu), .a2_i(io.malu), .a3_i(io.mmo), .s_i(fwda), .y_o(a_fwd));
    mux4x32 u_mux_b (.a0_i(io.dqb), .a1_i(io.ealu), .a2_i(io.malu), .a3_i(io.mmo), .s_i(fwdb), .y_o(b_fwd));

    always_comb begin
        e_d = stall ? '0 : estate_t'{wreg: io.dwreg, m2reg: io.dm2reg, wmem: io.dwmem, jal: io.djal,
                                     aluimm: io.daluimm, shift: io.dshift, aluc: io.daluc, rn0: io.drn0,
                                     pc4: io.dpc4, a: a_fwd, b: b_fwd, imm: io.dimm};
    end

    always_ff @(posedge clock) begin
        e_q <= !resetn ? '0 : e_d;
    end

    assign io.ewreg   = e_q.wreg;
    assign io.em2reg  = e_q.m2reg;
    assign io.ewmem   = e_q.wmem;
    assign io.ejal    = e_q.jal;
    assign io.ealuimm = e_q.aluimm;
    assign io.eshift  = e_q.shift;
    assign io.ealuc   = e_q.aluc;
    assign io.ern0    = e_q.rn0;
    assign io.epc4    = e_q.pc4;
    assign io.ea      = e_q.a;
    assign io.eb      = e_q.b;
    assign io.eimm    = e_q.imm;
    assign io.wpcir   = !stall;
    assign io.fwda    = fwda;
    assign io.fwdb    = fwdb;
endmodule

// File: tb/tb_pipe_issue.sv
// tb_pipe_issue: directed scenarios for forwarding, load-use bubbles and reset of pipe_issue.
module tb_pipe_issue;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int total = 0;
    int bad = 0;

    pipe_issue_if bus ();
    pipe_issue dut (.clock(clock), .resetn(resetn), .io(bus.slave));

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        {bus.dwreg, bus.dm2reg, bus.dwmem, bus.djal, bus.daluimm, bus.dshift} = '0;
        bus.daluc = '0; bus.dpc4 = '0; bus.dimm = '0; bus.dqa = '0; bus.dqb = '0;
        bus.drs = '0; bus.drt = '0; bus.drn0 = '0; bus.duse_rs = 0; bus.duse_rt = 0;
        bus.ern = '0; bus.ealu = '0; bus.mwreg = 0; bus.mm2reg = 0; bus.mrn = '0;
        bus.malu = '0; bus.mmo = '0;
    endtask

    // puts an instruction with the given write/load/dest into EXE
    task automatic issue_e(input logic wreg, input logic m2reg, input logic [4:0] rn);
        clear_in();
        bus.dwreg = wreg; bus.dm2reg = m2reg; bus.drn0 = rn;
        tick();
    endtask

    task automatic test_reset();
        clear_in();
        resetn = 0;
        {bus.dwreg, bus.dm2reg, bus.dwmem, bus.djal, bus.daluimm, bus.dshift} = '1;
        bus.daluc = 4'hF; bus.dpc4 = 32'h100; bus.dimm = 32'h55; bus.dqa = 32'h11; bus.dqb = 32'h22; bus.drn0 = 5'd9;
        tick(); tick();
        total++; if (bus.ewreg !== 1'b0) begin bad++; $display("FAIL reset_ewreg got=%0h exp=0", bus.ewreg); end
        total++; if ({bus.em2reg, bus.ewmem, bus.ejal, bus.ealuimm, bus.eshift} !== 5'b0) begin bad++; $display("FAIL reset_ctl got=%0h exp=0", {bus.em2reg, bus.ewmem, bus.ejal, bus.ealuimm, bus.eshift}); end
        total++; if (bus.ealuc !== 4'h0) begin bad++; $display("FAIL reset_ealuc got=%0h exp=0", bus.ealuc); end
        total++; if (bus.epc4 !== 32'h0) begin bad++; $display("FAIL reset_epc4 got=%0h exp=0", bus.epc4); end
        total++; if ({bus.ea, bus.eb, bus.eimm} !== 96'h0) begin bad++; $display("FAIL reset_ops got=%0h exp=0", {bus.ea, bus.eb, bus.eimm}); end
        total++; if (bus.ern0 !== 5'h0) begin bad++; $display("FAIL reset_ern0 got=%0h exp=0", bus.ern0); end
        total++; if (bus.wpcir !== 1'b1) begin bad++; $display("FAIL reset_wpcir got=%0h exp=1", bus.wpcir); end
        resetn = 1;
    endtask

    task automatic test_exe_fwd();
        issue_e(1, 0, 5);
        bus.dwreg = 0; bus.drn0 = 0;
        bus.ern = 5; bus.ealu = 32'h1234; bus.drs = 5; bus.dqa = 32'h0; bus.duse_rs = 1;
        #1;
        total++; if (bus.fwda !== 2'd1) begin bad++; $display("FAIL exe_fwda got=%0d exp=1", bus.fwda); end
        tick();
        total++; if (bus.ea !== 32'h1234) begin bad++; $display("FAIL exe_ea got=%0h exp=1234", bus.ea); end
    endtask

    task automatic test_mem_fwd();
        issue_e(1, 0, 5);
        bus.ern = 5; bus.ealu = 32'hBBBB; bus.mwreg = 1; bus.mrn = 5; bus.malu = 32'hAAAA;
        bus.drs = 5; bus.dqa = 32'h1; bus.drt = 3; bus.dqb = 32'h33; bus.duse_rs = 1; bus.duse_rt = 1;
        #1;
        total++; if (bus.fwda !== 2'd1) begin bad++; $display("FAIL prio_fwda got=%0d exp=1", bus.fwda); end
        tick();
        total++; if (bus.ea !== 32'hBBBB) begin bad++; $display("FAIL prio_ea got=%0h exp=bbbb", bus.ea); end
        total++; if (bus.eb !== 32'h33) begin bad++; $display("FAIL rf_eb got=%0h exp=33", bus.eb); end
        bus.ern = 6; bus.drt = 5;
        #1;
        total++; if (bus.fwda !== 2'd2) begin bad++; $display("FAIL mem_fwda got=%0d exp=2", bus.fwda); end
        total++; if (bus.fwdb !== 2'd2) begin bad++; $display("FAIL mem_fwdb got=%0d exp=2", bus.fwdb); end
        tick();
        total++; if (bus.ea !== 32'hAAAA) begin bad++; $display("FAIL mem_ea got=%0h exp=aaaa", bus.ea); end
        total++; if (bus.eb !== 32'hAAAA) begin bad++; $display("FAIL mem_eb got=%0h exp=aaaa", bus.eb); end
    endtask

    task automatic test_load_use();
        issue_e(1, 1, 7);
        total++; if ({bus.ewreg, bus.em2reg, bus.ern0} !== {2'b11, 5'd7}) begin bad++; $display("FAIL lw_in_e got=%0h exp=%0h", {bus.ewreg, bus.em2reg, bus.ern0}, {2'b11, 5'd7}); end
        bus.dm2reg = 0; bus.dwreg = 1; bus.dwmem = 1; bus.dpc4 = 32'h40; bus.drn0 = 5'd2;
        bus.ern = 7; bus.drt = 7; bus.duse_rt = 1; bus.dqb = 32'h99;
        #1;
        total++; if (bus.wpcir !== 1'b0) begin bad++; $display("FAIL lu_wpcir got=%0h exp=0", bus.wpcir); end
        tick();
        total++; if ({bus.ewreg, bus.ewmem} !== 2'b00) begin bad++; $display("FAIL lu_bubble got=%0h exp=0", {bus.ewreg, bus.ewmem}); end
        total++; if ({bus.epc4, bus.eb, bus.ern0} !== 69'h0) begin bad++; $display("FAIL lu_bubble_ops got=%0h exp=0", {bus.epc4, bus.eb, bus.ern0}); end
        bus.ern = 0; bus.mwreg = 1; bus.mm2reg = 1; bus.mrn = 7; bus.mmo = 32'hCAFE;
        #1;
        total++; if (bus.wpcir !== 1'b1) begin bad++; $display("FAIL lu_resume_wpcir got=%0h exp=1", bus.wpcir); end
        total++; if (bus.fwdb !== 2'd3) begin bad++; $display("FAIL lu_fwdb got=%0d exp=3", bus.fwdb); end
        tick();
        total++; if (bus.eb !== 32'hCAFE) begin bad++; $display("FAIL lu_eb got=%0h exp=cafe", bus.eb); end
        total++; if ({bus.epc4, bus.ewmem, bus.ern0} !== {32'h40, 1'b1, 5'd2}) begin bad++; $display("FAIL lu_reissue got=%0h exp=%0h", {bus.epc4, bus.ewmem, bus.ern0}, {32'h40, 1'b1, 5'd2}); end
    endtask

    task automatic test_both_and_stall_wins();
        issue_e(1, 1, 7);
        bus.ern = 7; bus.drs = 7; bus.drt = 7; bus.duse_rs = 1; bus.duse_rt = 1; bus.dwreg = 1;
        bus.mwreg = 1; bus.mrn = 7; bus.malu = 32'h5151; bus.dqa = 32'h10;
        #1;
        total++; if (bus.wpcir !== 1'b0) begin bad++; $display("FAIL both_wpcir got=%0h exp=0", bus.wpcir); end
        total++; if (bus.fwda !== 2'd2) begin bad++; $display("FAIL stallwin_fwda got=%0d exp=2", bus.fwda); end
        tick();
        total++; if ({bus.ea, bus.eb, bus.ewreg} !== 65'h0) begin bad++; $display("FAIL stallwin_ea got=%0h exp=0", {bus.ea, bus.eb, bus.ewreg}); end
        bus.ern = 0; bus.mm2reg = 1; bus.mmo = 32'h7777;
        #1;
        total++; if (bus.wpcir !== 1'b1) begin bad++; $display("FAIL both_single got=%0h exp=1", bus.wpcir); end
        tick();
        total++; if ({bus.ea, bus.eb} !== {32'h7777, 32'h7777}) begin bad++; $display("FAIL both_mmo got=%0h exp=77777777", {bus.ea, bus.eb}); end
    endtask

    task automatic test_r0_and_unused();
        issue_e(1, 1, 0);
        bus.ern = 0; bus.drs = 0; bus.duse_rs = 1; bus.dqa = 32'h55; bus.mwreg = 1; bus.mrn = 0; bus.malu = 32'hEE;
        #1;
        total++; if (bus.wpcir !== 1'b1) begin bad++; $display("FAIL r0_wpcir got=%0h exp=1", bus.wpcir); end
        total++; if (bus.fwda !== 2'd0) begin bad++; $display("FAIL r0_fwda got=%0d exp=0", bus.fwda); end
        tick();
        total++; if (bus.ea !== 32'h55) begin bad++; $display("FAIL r0_ea got=%0h exp=55", bus.ea); end
        issue_e(1, 1, 7);
        bus.ern = 7; bus.drt = 7; bus.duse_rt = 0; bus.drs = 3; bus.duse_rs = 1; bus.dqb = 32'h66; bus.dwreg = 1;
        #1;
        total++; if (bus.wpcir !== 1'b1) begin bad++; $display("FAIL unused_wpcir got=%0h exp=1", bus.wpcir); end
        tick();
        total++; if ({bus.ewreg, bus.eb} !== {1'b1, 32'h66}) begin bad++; $display("FAIL unused_issue got=%0h exp=%0h", {bus.ewreg, bus.eb}, {1'b1, 32'h66}); end
    endtask

    task automatic test_jal();
        clear_in();
        bus.dwreg = 1; bus.djal = 1; bus.drn0 = 5'd0; bus.dpc4 = 32'h104;
        tick();
        total++; if ({bus.ejal, bus.epc4} !== {1'b1, 32'h104}) begin bad++; $display("FAIL jal_e got=%0h exp=%0h", {bus.ejal, bus.epc4}, {1'b1, 32'h104}); end
        bus.djal = 0; bus.dwreg = 0; bus.ern = 31; bus.ealu = 32'h108; bus.drs = 31; bus.duse_rs = 1; bus.dqa = 32'h1;
        #1;
        total++; if (bus.fwda !== 2'd1) begin bad++; $display("FAIL jal_fwda got=%0d exp=1", bus.fwda); end
        tick();
        total++; if (bus.ea !== 32'h108) begin bad++; $display("FAIL jal_ea got=%0h exp=108", bus.ea); end
    endtask

    task automatic test_back_to_back();
        issue_e(1, 1, 7);
        bus.ern = 7; bus.dwreg = 1; bus.dm2reg = 1; bus.drn0 = 8; bus.drs = 7; bus.duse_rs = 1;
        #1;
        total++; if (bus.wpcir !== 1'b0) begin bad++; $display("FAIL b2b_stall1 got=%0h exp=0", bus.wpcir); end
        tick();
        bus.ern = 0; bus.mwreg = 1; bus.mm2reg = 1; bus.mrn = 7; bus.mmo = 32'h11;
        #1;
        total++; if (bus.wpcir !== 1'b1) begin bad++; $display("FAIL b2b_go1 got=%0h exp=1", bus.wpcir); end
        tick();
        total++; if ({bus.ea, bus.em2reg, bus.ern0} !== {32'h11, 1'b1, 5'd8}) begin bad++; $display("FAIL b2b_load2 got=%0h exp=%0h", {bus.ea, bus.em2reg, bus.ern0}, {32'h11, 1'b1, 5'd8}); end
        bus.ern = 8; bus.mwreg = 0; bus.dm2reg = 0; bus.drn0 = 9; bus.drs = 8;
        #1;
        total++; if (bus.wpcir !== 1'b0) begin bad++; $display("FAIL b2b_stall2 got=%0h exp=0", bus.wpcir); end
    endtask

    task automatic test_reset_in_stall();
        issue_e(1, 1, 7);
        bus.ern = 7; bus.drs = 7; bus.duse_rs = 1; bus.dwreg = 1; bus.dpc4 = 32'h77;
        #1;
        total++; if (bus.wpcir !== 1'b0) begin bad++; $display("FAIL rst_stall_pre got=%0h exp=0", bus.wpcir); end
        resetn = 0;
        tick();
        total++; if ({bus.ewreg, bus.em2reg, bus.epc4, bus.ern0} !== 39'h0) begin bad++; $display("FAIL rst_stall_e got=%0h exp=0", {bus.ewreg, bus.em2reg, bus.epc4, bus.ern0}); end
        total++; if (bus.wpcir !== 1'b1) begin bad++; $display("FAIL rst_stall_wpcir got=%0h exp=1", bus.wpcir); end
        resetn = 1;
    endtask

    initial begin
        test_reset();
        test_exe_fwd();
        test_mem_fwd();
        test_load_use();
        test_both_and_stall_wins();
        test_r0_and_unused();
        test_jal();
        test_back_to_back();
        test_reset_in_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
